// File: rtl/tacho_pkg.sv
// rtl/tacho_pkg.sv - shared field positions, state encoding and defaults for the tacho period meter
package tacho_pkg;

  localparam int VALID_BIT = 31;
  localparam int STALL_BIT = 30;
  localparam int CNT_MSB   = 29;
  localparam int CNT_LSB   = 24;
  localparam int PER_MSB   = 23;

  localparam int          DEF_PERIOD_WIDTH = 24;
  localparam logic [23:0] DEF_TIMEOUT      = 24'hFFFFFF;
  localparam int          DEF_MIN_PERIOD   = 16;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    STALLED    = 2'd2
  } tacho_state_t;

endpackage

// File: rtl/tacho_input_sync.sv
// rtl/tacho_input_sync.sv - 3-flop synchroniser with rising-edge pulse, reset to ones
module tacho_input_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [2:0] sync;

  // Reset to ones so an input that is already high after reset gives no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 3'b111;
    end else begin
      sync <= {sync[1:0], din};
    end
  end

  assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/tacho_period_meter.sv
// rtl/tacho_period_meter.sv - tachometer period meter with glitch reject, stall detect and atomic status word
module tacho_period_meter
  import tacho_pkg::*;
#(
  parameter int                      PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter logic [PERIOD_WIDTH-1:0] TIMEOUT      = DEF_TIMEOUT,
  parameter int                      MIN_PERIOD   = DEF_MIN_PERIOD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tacho,
  output logic [31:0] data,
  output logic        update
);

  localparam logic [PERIOD_WIDTH-1:0] MIN_COUNT = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] ONE       = PERIOD_WIDTH'(1);

  tacho_state_t                 state, state_next;
  logic [PERIOD_WIDTH-1:0]      counter, counter_next;
  logic [31:0]                  data_next;
  logic                         update_next;
  logic                         rise;
  logic [CNT_MSB-CNT_LSB:0]     cnt_inc;
  logic                         at_timeout;
  logic                         long_enough;

  tacho_input_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (tacho),
    .rise  (rise)
  );

  assign cnt_inc     = data[CNT_MSB:CNT_LSB] + 1'b1;
  assign at_timeout  = (counter == TIMEOUT);
  assign long_enough = (counter >= MIN_COUNT);

  // Every branch that changes data also raises update, so the word is only ever
  // replaced whole in one register load.
  always_comb begin
    state_next   = state;
    counter_next = at_timeout ? counter : counter + 1'b1;
    data_next    = data;
    update_next  = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (rise) begin
          state_next                    = MEASURE;
          counter_next                  = ONE;
          data_next[CNT_MSB:CNT_LSB]    = cnt_inc;
          update_next                   = 1'b1;
        end else if (at_timeout) begin
          state_next                    = STALLED;
          data_next[VALID_BIT]          = 1'b0;
          data_next[STALL_BIT]          = 1'b1;
          data_next[PER_MSB:0]          = '1;
          update_next                   = 1'b1;
        end
      end
      MEASURE: begin
        // An edge at the timeout count wins over the stall.
        if (rise && long_enough) begin
          counter_next                  = ONE;
          data_next[VALID_BIT]          = 1'b1;
          data_next[STALL_BIT]          = 1'b0;
          data_next[CNT_MSB:CNT_LSB]    = cnt_inc;
          data_next[PER_MSB:0]          = counter;
          update_next                   = 1'b1;
        end else if (at_timeout) begin
          state_next                    = STALLED;
          data_next[VALID_BIT]          = 1'b0;
          data_next[STALL_BIT]          = 1'b1;
          data_next[PER_MSB:0]          = '1;
          update_next                   = 1'b1;
        end
      end
      STALLED: begin
        if (rise) begin
          state_next                    = MEASURE;
          counter_next                  = ONE;
          data_next[STALL_BIT]          = 1'b0;
          data_next[CNT_MSB:CNT_LSB]    = cnt_inc;
          update_next                   = 1'b1;
        end
      end
      default: begin
        state_next = WAIT_FIRST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WAIT_FIRST;
      counter <= '0;
      data    <= 32'h0;
      update  <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      data    <= data_next;
      update  <= update_next;
    end
  end

endmodule

// File: tb/tb_tacho_period_meter.sv
// tb/tb_tacho_period_meter.sv - directed self-checking bench for tacho_period_meter
module tb_tacho_period_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tacho = 1'b1;
  logic [31:0] data;
  logic        update;

  int checks = 0;
  int errors = 0;

  int          ncyc = 0;
  int          upd_count = 0;
  int          last_upd = 0;
  int          prev_upd = 0;
  int          bad_change = 0;
  logic        rst_q = 1'b1;
  logic [31:0] prev_data = 32'h0;

  typedef struct {
    int          gap;
    int          exp_upd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  tacho_period_meter #(
    .PERIOD_WIDTH (24),
    .TIMEOUT      (24'd1000),
    .MIN_PERIOD   (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .tacho  (tacho),
    .data   (data),
    .update (update)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= reset;

  // Update log plus a watch that data never moves without update (reset excepted).
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (update === 1'b1) begin
      upd_count = upd_count + 1;
      prev_upd  = last_upd;
      last_upd  = ncyc;
    end else if (rst_q === 1'b0 && data !== prev_data) begin
      bad_change = bad_change + 1;
    end
    prev_data = data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tacho = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle tacho pulse rising gap cycles after the previous one; returns 5 cycles after the rise.
  task automatic pulse_after(input int gap);
    repeat (gap - 5) @(negedge clk);
    tacho = 1'b1;
    @(negedge clk);
    tacho = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int base;

    vecs[0] = '{20,   1, 32'h01000000};
    vecs[1] = '{100,  1, 32'h82000064};
    vecs[2] = '{100,  1, 32'h83000064};
    vecs[3] = '{37,   1, 32'h84000025};
    vecs[4] = '{6,    1, 32'h85000006};
    vecs[5] = '{1000, 1, 32'h860003E8};

    // Tacho high through reset, never toggling: stall after TIMEOUT cycles.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_data", data, 32'h0);
    check("reset_update", 32'(update), 32'h0);
    repeat (999) @(negedge clk);
    check("pre_stall_update", 32'(update), 32'h0);
    check("pre_stall_count", 32'(upd_count), 32'h0);
    check("pre_stall_data", data, 32'h0);
    @(negedge clk);
    check("first_stall_update", 32'(update), 32'h1);
    check("first_stall_data", data, 32'h40FFFFFF);
    tacho = 1'b0;

    do_reset();
    for (int i = 0; i < 6; i++) begin
      base = upd_count;
      pulse_after(vecs[i].gap);
      check($sformatf("vec%0d_updates", i), 32'(upd_count - base), 32'(vecs[i].exp_upd));
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end

    // Glitch two cycles after an accepted edge is ignored.
    repeat (95) @(negedge clk);
    base = upd_count;
    tacho = 1'b1;
    @(negedge clk);
    tacho = 1'b0;
    @(negedge clk);
    tacho = 1'b1;
    @(negedge clk);
    tacho = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_updates", 32'(upd_count - base), 32'h1);
    check("glitch_data", data, 32'h87000064);
    repeat (94) @(negedge clk);
    base = upd_count;
    tacho = 1'b1;
    @(negedge clk);
    tacho = 1'b0;
    repeat (4) @(negedge clk);
    check("post_glitch_updates", 32'(upd_count - base), 32'h1);
    check("post_glitch_data", data, 32'h88000064);

    // Edge exactly at MIN_PERIOD is accepted.
    repeat (95) @(negedge clk);
    base = upd_count;
    tacho = 1'b1;
    @(negedge clk);
    tacho = 1'b0;
    repeat (3) @(negedge clk);
    tacho = 1'b1;
    @(negedge clk);
    tacho = 1'b0;
    repeat (4) @(negedge clk);
    check("min_period_updates", 32'(upd_count - base), 32'h2);
    check("min_period_data", data, 32'h8A000004);

    // Stop edges: stall exactly TIMEOUT cycles after the last update, then recover.
    base = upd_count;
    repeat (1010) @(negedge clk);
    check("stall_updates", 32'(upd_count - base), 32'h1);
    check("stall_data", data, 32'h4AFFFFFF);
    check("stall_delay", 32'(last_upd - prev_upd), 32'd1000);
    base = upd_count;
    pulse_after(20);
    check("recover_updates", 32'(upd_count - base), 32'h1);
    check("recover_data", data, 32'h0BFFFFFF);
    pulse_after(250);
    check("recover_period", data, 32'h8C0000FA);

    // One-cycle reset mid-period.
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_data", data, 32'h0);
    check("midreset_update", 32'(update), 32'h0);
    pulse_after(50);
    check("midreset_first", data, 32'h01000000);
    pulse_after(100);
    check("midreset_second", data, 32'h82000064);

    // Edge count wraps modulo 64.
    do_reset();
    base = upd_count;
    for (int i = 0; i < 70; i++) begin
      pulse_after(20);
      if (i == 63) check("wrap_to_zero", data, 32'h80000014);
    end
    check("wrap_updates", 32'(upd_count - base), 32'd70);
    check("wrap_data", data, 32'h86000014);

    check("data_changed_without_update", 32'(bad_change), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
